uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..8).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning tick strobes per bit period.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tick  input  1  one-clk strobe at OVERSAMPLE x baud, from baudrate_gen.
REQ-007 SHALL have port req  input  2  per-requester transmit request, level, held until granted.
REQ-008 SHALL have port data0  input  DATA_BITS  byte from requester 0.
REQ-009 SHALL have port data1  input  DATA_BITS  byte from requester 1.
REQ-010 SHALL have port gnt  output  2  one-clk one-hot accept pulse to the served requester.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port done  output  1  one-clk pulse at end of final stop bit.

Function
REQ-014 SHALL implement states IDLE, START, DATA, STOP; busy = (state != IDLE), registered.
REQ-015 In IDLE with any req high, SHALL in one clk: pulse gnt for the winner, latch its data, drive tx=0, clear tick and bit counters, enter START.
REQ-016 Arbitration SHALL be round-robin: winner is the requester not served last; if only one requests, it wins regardless.
REQ-017 req deasserted before grant SHALL be ignored; data is sampled only in the grant cycle.
REQ-018 Tick counter SHALL advance only on tick; each bit period ends on the tick where counter == OVERSAMPLE-1, counter then wraps to 0.
REQ-019 START SHALL last one bit period, then DATA with tx = latched bit 0.
REQ-020 DATA SHALL send DATA_BITS bits LSB first, one bit period each, then STOP with tx=1.
REQ-021 STOP SHALL last STOP_BITS bit periods; on its final tick, SHALL pulse done and enter IDLE.
REQ-022 A req pending at done SHALL be granted in the first IDLE clk (no extra idle bit); tx stays 1 in between.
REQ-023 tick in IDLE SHALL be ignored; absence of tick SHALL hold state, counters and tx unchanged.
REQ-024 gnt and done SHALL never be asserted in the same clk.

Reset
REQ-025 On reset: tx=1, busy=0, gnt=0, done=0, state IDLE, counters 0, last-served pointer = 1 (requester 0 wins first).
REQ-026 Reset mid-frame SHALL abandon the frame immediately, with no done pulse and no later resumption.

Structure
REQ-027 Package uart_pkg SHALL hold the state typedef and default constants (OVERSAMPLE=16, DATA_BITS=8).
REQ-028 The 2-way round-robin grant logic SHALL be a sub-module uart_rr_arbiter (req, advance, gnt, last pointer).

Verification
REQ-029 8N1, req0 held with data0=0x55, tick every 4 clk -> gnt=01 once; tx = 0,1,0,1,0,1,0,1,0,1, each for 16 ticks; done after 160 ticks.
REQ-030 req=11 held, data0=0xA5, data1=0x3C -> frames 0xA5 then 0x3C back-to-back; gnt=01 then 10; tx never low between the two frames except at start bits.
REQ-031 STOP_BITS=2, data1=0xFF -> frame length 176 ticks; done pulses exactly once.
REQ-032 Reset asserted during DATA bit 3 -> tx=1 and busy=0 at once; no done; next req0 starts a fresh frame from START.
REQ-033 tick held low 1000 clk mid-bit -> tx and state frozen; resumes on next tick with the same bit.
REQ-034 req1 pulsed for one clk during a busy frame, then dropped -> never granted; no extra frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default framing constants for the UART transmit scheduler.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_STOP_BITS  = 1;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Two-requester transmit handshake: level req + data in, one-clk gnt pulse out.
interface uart_tx_scheduler_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS
);

   logic [1:0]           req;
   logic [DATA_BITS-1:0] data0;
   logic [DATA_BITS-1:0] data1;
   logic [1:0]           gnt;

   modport master (
      output req,
      output data0,
      output data1,
      input  gnt
   );

   modport slave (
      input  req,
      input  data0,
      input  data1,
      output gnt
   );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Two-way round-robin arbiter; last pointer moves to the winner on advance.
module uart_rr_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = 2'b00;
      unique case (1'b1)
         (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
         (req == 2'b01): gnt = 2'b01;
         (req == 2'b10): gnt = 2'b10;
         default:        gnt = 2'b00;
      endcase
   end

   // Reset to 1 so requester 0 wins the first contested round.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last <= 1'b1;
      end else if (advance) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART frame transmitter shared by two requesters under round-robin arbitration.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int STOP_BITS  = DEF_STOP_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   uart_tx_scheduler_if.slave bus,
   output logic               tx,
   output logic               busy,
   output logic               done
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   state_t               state;
   logic [TW-1:0]        tick_cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           win;
   logic                 start;
   logic                 period_end;

   assign start      = (state == IDLE) && (|bus.req);
   assign period_end = tick && (tick_cnt == TICK_LAST);

   uart_rr_arbiter u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (bus.req),
      .advance (start),
      .gnt     (win)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         bus.gnt  <= 2'b00;
      end else begin
         bus.gnt <= 2'b00;
         done    <= 1'b0;
         if (state != IDLE && tick) begin
            tick_cnt <= period_end ? '0 : tick_cnt + 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  bus.gnt  <= win;
                  shreg    <= win[1] ? bus.data1 : bus.data0;
                  tx       <= 1'b0;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (period_end) begin
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                  state <= DATA;
               end
            end
            DATA: begin
               if (period_end) begin
                  if (bit_cnt == DATA_LAST) begin
                     tx      <= 1'b1;
                     bit_cnt <= '0;
                     state   <= STOP;
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (period_end) begin
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: 8N1 and 8N2 instances against a frame-level model.
module tb_uart_tx_scheduler;

   logic clk;
   logic reset;
   logic tick;
   logic tx0, busy0, done0;
   logic tx1, busy1, done1;

   uart_tx_scheduler_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_scheduler_if #(.DATA_BITS(8)) bus1 ();

   uart_tx_scheduler #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16)) dut0 (
      .clk(clk), .reset(reset), .tick(tick), .bus(bus0),
      .tx(tx0), .busy(busy0), .done(done0)
   );

   uart_tx_scheduler #(.DATA_BITS(8), .STOP_BITS(2), .OVERSAMPLE(16)) dut1 (
      .clk(clk), .reset(reset), .tick(tick), .bus(bus1),
      .tx(tx1), .busy(busy1), .done(done1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int tick_mode = 0;
   int tdiv  = 0;
   bit rnd   = 1'b0;

   // frame model: a frame is a list of line levels, each lasting 16 ticks
   int         nstop[2] = '{1, 2};
   bit         m_busy[2];
   int         m_pos[2];
   int         m_tc[2];
   int         m_last[2];
   logic [11:0] m_frame[2];
   logic [1:0] m_gnt[2];
   logic       m_done[2];

   int         gcnt[2] = '{0, 0};
   int         dcnt[2] = '{0, 0};
   int         cur[2]  = '{0, 0};
   int         last_done[2] = '{-1000, -1000};
   logic [11:0] txv[2];
   logic       prev_busy[2];
   logic       prev_tx[2];
   int         ftq0[$];
   int         ftq1[$];
   logic [11:0] txq0[$];
   logic [1:0] glog0[$];
   int         gapq0[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_step(input int k, input logic rst, input logic [1:0] r,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic tk);
      int w;
      m_gnt[k]  = 2'b00;
      m_done[k] = 1'b0;
      if (rst) begin
         m_busy[k] = 1'b0;
         m_last[k] = 1;
         m_pos[k]  = 0;
         m_tc[k]   = 0;
      end else if (!m_busy[k]) begin
         if (r != 2'b00) begin
            if (r == 2'b11) w = (m_last[k] == 1) ? 0 : 1;
            else w = r[1] ? 1 : 0;
            m_last[k]  = w;
            m_gnt[k]   = (w == 1) ? 2'b10 : 2'b01;
            m_frame[k] = {3'b111, (w == 1) ? b : a, 1'b0};
            m_busy[k]  = 1'b1;
            m_pos[k]   = 0;
            m_tc[k]    = 0;
         end
      end else if (tk) begin
         if (m_tc[k] == 15) begin
            m_tc[k] = 0;
            m_pos[k]++;
            if (m_pos[k] == 9 + nstop[k]) begin
               m_busy[k] = 1'b0;
               m_done[k] = 1'b1;
            end
         end else begin
            m_tc[k]++;
         end
      end
   endtask

   function automatic logic [31:0] exp_vec(input int k);
      logic etx;
      etx = m_busy[k] ? m_frame[k][m_pos[k]] : 1'b1;
      return {27'd0, etx, m_busy[k], m_gnt[k], m_done[k]};
   endfunction

   task automatic observe(input int k, input logic rst, input logic tk,
                          input logic [1:0] g, input logic d,
                          input logic b, input logic t);
      if (rst) begin
         cur[k]       = 0;
         txv[k]       = '0;
         last_done[k] = -1000;
      end else begin
         if (prev_busy[k] === 1'b1 && tk) begin
            if (cur[k] % 16 == 8 && cur[k] / 16 < 12)
               txv[k][cur[k] / 16] = prev_tx[k];
            cur[k]++;
         end
         if (g != 2'b00) begin
            gcnt[k]++;
            if (k == 0) begin
               glog0.push_back(g);
               gapq0.push_back(cyc - last_done[k]);
            end
         end
         if (d) begin
            dcnt[k]++;
            last_done[k] = cyc;
            if (k == 0) begin
               ftq0.push_back(cur[k]);
               txq0.push_back(txv[k]);
            end else begin
               ftq1.push_back(cur[k]);
            end
            cur[k] = 0;
            txv[k] = '0;
         end
      end
      prev_busy[k] = b;
      prev_tx[k]   = t;
   endtask

   function automatic int ft_at(input int k, input int back);
      if (k == 0) return (ftq0.size() > back) ? ftq0[ftq0.size()-1-back] : -1;
      return (ftq1.size() > back) ? ftq1[ftq1.size()-1-back] : -1;
   endfunction

   function automatic logic [11:0] tx_at(input int back);
      return (txq0.size() > back) ? txq0[txq0.size()-1-back] : 12'hFFF;
   endfunction

   function automatic logic [1:0] g_at(input int back);
      return (glog0.size() > back) ? glog0[glog0.size()-1-back] : 2'b11;
   endfunction

   function automatic int gap_at(input int back);
      return (gapq0.size() > back) ? gapq0[gapq0.size()-1-back] : -1;
   endfunction

   // compare process: model advances on each edge, DUT checked just after it
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_step(0, reset, bus0.req, bus0.data0, bus0.data1, tick);
         model_step(1, reset, bus1.req, bus1.data0, bus1.data1, tick);
         #1;
         observe(0, reset, tick, bus0.gnt, done0, busy0, tx0);
         observe(1, reset, tick, bus1.gnt, done1, busy1, tx1);
         check($sformatf("cyc%0d_u0", cyc),
               {27'd0, tx0, busy0, bus0.gnt, done0}, exp_vec(0));
         check($sformatf("cyc%0d_u1", cyc),
               {27'd0, tx1, busy1, bus1.gnt, done1}, exp_vec(1));
      end
   end

   function automatic logic [1:0] rnd_req(input logic [1:0] r,
                                          input logic [1:0] g);
      logic [1:0] n;
      n = r;
      for (int i = 0; i < 2; i++) begin
         if (r[i] && g[i]) n[i] = 1'b0;
         else if (!r[i] && $urandom_range(59) == 0) n[i] = 1'b1;
         else if (r[i] && $urandom_range(299) == 0) n[i] = 1'b0;
      end
      return n;
   endfunction

   // driver: ticks, request release on grant, random traffic
   initial begin
      forever begin
         @(negedge clk);
         case (tick_mode)
            1: begin
               tdiv = (tdiv + 1) % 4;
               tick = (tdiv == 0);
            end
            2: tick = ($urandom_range(2) == 0);
            default: tick = 1'b0;
         endcase
         if (rnd) begin
            bus0.data0 = 8'($urandom);
            bus0.data1 = 8'($urandom);
            bus1.data0 = 8'($urandom);
            bus1.data1 = 8'($urandom);
            bus0.req = rnd_req(bus0.req, bus0.gnt);
            bus1.req = rnd_req(bus1.req, bus1.gnt);
         end else begin
            bus0.req = bus0.req & ~bus0.gnt;
            bus1.req = bus1.req & ~bus1.gnt;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_done(input int k, input int target, input int lim,
                            input string name);
      int n = 0;
      while (dcnt[k] < target && n < lim) begin
         @(negedge clk);
         n++;
      end
      check({name, "_wait_done"}, 32'(dcnt[k] >= target), 32'd1);
   endtask

   task automatic wait_ticks(input int k, input int target, input int lim,
                             input string name);
      int n = 0;
      while (cur[k] < target && n < lim) begin
         @(negedge clk);
         n++;
      end
      check({name, "_wait_ticks"}, 32'(cur[k] >= target), 32'd1);
   endtask

   initial begin
      int g, d, g1, d1, n;
      reset = 1'b1;
      tick  = 1'b0;
      bus0.req = 2'b00; bus0.data0 = '0; bus0.data1 = '0;
      bus1.req = 2'b00; bus1.data0 = '0; bus1.data1 = '0;
      tick_mode = 1;
      repeat (3) @(negedge clk);
      check("rst_u0", {27'd0, tx0, busy0, bus0.gnt, done0}, 32'h10);
      check("rst_u1", {27'd0, tx1, busy1, bus1.gnt, done1}, 32'h10);
      reset = 1'b0;

      // 8N1, 0x55 from requester 0
      do_reset();
      g = gcnt[0]; d = dcnt[0];
      bus0.data0 = 8'h55; bus0.req = 2'b01;
      wait_done(0, d + 1, 3000, "t1");
      repeat (20) @(negedge clk);
      check("t1_gnt_count", 32'(gcnt[0] - g), 32'd1);
      check("t1_gnt_value", 32'(g_at(0)), 32'h1);
      check("t1_ticks", 32'(ft_at(0, 0)), 32'd160);
      check("t1_bits", 32'(tx_at(0)), 32'h2AA);
      check("t1_done_count", 32'(dcnt[0] - d), 32'd1);

      // both requesting: 0xA5 then 0x3C back-to-back
      do_reset();
      d = dcnt[0];
      bus0.data0 = 8'hA5; bus0.data1 = 8'h3C; bus0.req = 2'b11;
      wait_done(0, d + 2, 5000, "t2");
      check("t2_gnt_first", 32'(g_at(1)), 32'h1);
      check("t2_gnt_second", 32'(g_at(0)), 32'h2);
      check("t2_bits_a5", 32'(tx_at(1)), 32'h34A);
      check("t2_bits_3c", 32'(tx_at(0)), 32'h278);
      check("t2_ticks", 32'(ft_at(0, 0)), 32'd160);
      check("t2_gap", 32'(gap_at(0)), 32'd1);

      // two stop bits, 0xFF from requester 1
      do_reset();
      g1 = gcnt[1]; d1 = dcnt[1];
      bus1.data1 = 8'hFF; bus1.req = 2'b10;
      wait_done(1, d1 + 1, 3000, "t3");
      repeat (100) @(negedge clk);
      check("t3_ticks", 32'(ft_at(1, 0)), 32'd176);
      check("t3_done_count", 32'(dcnt[1] - d1), 32'd1);
      check("t3_gnt_count", 32'(gcnt[1] - g1), 32'd1);

      // reset during data bit 3
      do_reset();
      bus0.data0 = 8'h00; bus0.req = 2'b01;
      wait_ticks(0, 69, 2000, "t4");
      check("t4_tx_before", 32'(tx0), 32'd0);
      d = dcnt[0];
      reset = 1'b1;
      #1;
      check("t4_tx_reset", 32'(tx0), 32'd1);
      check("t4_busy_reset", 32'(busy0), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (300) @(negedge clk);
      check("t4_no_done", 32'(dcnt[0] - d), 32'd0);
      check("t4_idle", 32'(busy0), 32'd0);
      bus0.data0 = 8'h55; bus0.req = 2'b01;
      wait_done(0, d + 1, 3000, "t4b");
      check("t4_fresh_ticks", 32'(ft_at(0, 0)), 32'd160);
      check("t4_fresh_bits", 32'(tx_at(0)), 32'h2AA);

      // tick stalled mid-bit
      do_reset();
      d = dcnt[0];
      bus0.data0 = 8'h55; bus0.req = 2'b01;
      wait_ticks(0, 40, 2000, "t5");
      tick_mode = 0;
      repeat (1000) @(negedge clk);
      check("t5_frozen_tx", 32'(tx0), 32'd0);
      check("t5_frozen_busy", 32'(busy0), 32'd1);
      tick_mode = 1;
      wait_done(0, d + 1, 3000, "t5b");
      check("t5_ticks", 32'(ft_at(0, 0)), 32'd160);
      check("t5_bits", 32'(tx_at(0)), 32'h2AA);

      // short req1 pulse while busy is never served
      do_reset();
      g = gcnt[0]; d = dcnt[0];
      bus0.data0 = 8'h55; bus0.req = 2'b01;
      wait_ticks(0, 20, 2000, "t6");
      bus0.req = bus0.req | 2'b10;
      @(negedge clk);
      bus0.req = bus0.req & 2'b01;
      wait_done(0, d + 1, 3000, "t6b");
      repeat (400) @(negedge clk);
      check("t6_gnt_count", 32'(gcnt[0] - g), 32'd1);
      check("t6_done_count", 32'(dcnt[0] - d), 32'd1);

      // random traffic on both instances
      do_reset();
      tick_mode = 2;
      rnd = 1'b1;
      repeat (8000) @(negedge clk);
      rnd = 1'b0;
      bus0.req = 2'b00;
      bus1.req = 2'b00;
      tick_mode = 1;
      n = 0;
      while ((busy0 || busy1) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_idle", 32'(busy0 | busy1), 32'd0);
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
